// File: rtl/redundant_sum_resolver_pkg.sv
// Shared sizing helpers for the segmented carry-propagate resolver.
// Segment count and the width of the (possibly narrower) top segment.
package resolver_pkg;

  function automatic int seg_count(input int out_len, input int seg_len);
    return (out_len + seg_len - 32'sd1) / seg_len;
  endfunction

  function automatic int last_seg_len(input int out_len, input int seg_len);
    return out_len - (seg_count(out_len, seg_len) - 32'sd1) * seg_len;
  endfunction

endpackage

// File: rtl/redundant_sum_resolver_segment_carry_stage.sv
// One carry-resolve pipeline stage: adds segment SEG_IDX of s/c plus the
// incoming carry, and forwards the operand vectors and resolved bits onward.
module segment_carry_stage #(
  parameter int OUT_LEN = 25,
  parameter int SEG_LEN = 8,
  parameter int SEG_IDX = 0,
  parameter int SEG_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
  input  logic               v_in,
  input  logic               carry_in,
  input  logic [OUT_LEN-1:0] s_in,
  input  logic [OUT_LEN-1:0] c_in,
  input  logic [OUT_LEN-1:0] res_in,
  output logic               v_out,
  output logic               carry_out,
  output logic [OUT_LEN-1:0] s_out,
  output logic [OUT_LEN-1:0] c_out,
  output logic [OUT_LEN-1:0] res_out
);

  localparam int LO = SEG_IDX * SEG_LEN;

  logic [SEG_W:0]       seg_sum_s;
  logic [OUT_LEN-1:0]   res_next_s;
  logic                 v_r;
  logic                 carry_r;
  logic [OUT_LEN-1:0]   s_r;
  logic [OUT_LEN-1:0]   c_r;
  logic [OUT_LEN-1:0]   res_r;

  // Segment add; lower resolved bits pass through, this segment is replaced.
  always_comb begin
    seg_sum_s = {1'b0, s_in[LO +: SEG_W]} + {1'b0, c_in[LO +: SEG_W]}
              + {{SEG_W{1'b0}}, carry_in};
    res_next_s = res_in;
    res_next_s[LO +: SEG_W] = seg_sum_s[SEG_W-1:0];
  end

  // Stage register: all fields advance together or hold together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r     <= 1'b0;
      carry_r <= 1'b0;
      s_r     <= '0;
      c_r     <= '0;
      res_r   <= '0;
    end else if (adv) begin
      v_r     <= v_in;
      carry_r <= seg_sum_s[SEG_W];
      s_r     <= s_in;
      c_r     <= c_in;
      res_r   <= res_next_s;
    end else begin
      v_r     <= v_r;
      carry_r <= carry_r;
      s_r     <= s_r;
      c_r     <= c_r;
      res_r   <= res_r;
    end
  end

  assign v_out     = v_r;
  assign carry_out = carry_r;
  assign s_out     = s_r;
  assign c_out     = c_r;
  assign res_out   = res_r;

endmodule

// File: rtl/redundant_sum_resolver.sv
// Resolves the compressor tree's three redundant vectors into a binary sum:
// one 3:2 CSA stage, then a segmented carry chain, one segment per cycle.
module redundant_sum_resolver
  import resolver_pkg::*;
#(
  parameter int BIT_LEN = 23,
  parameter int SEG_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BIT_LEN-1:0]   C1,
  input  logic [BIT_LEN-1:0]   C,
  input  logic [BIT_LEN-1:0]   S,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_LEN+1:0]   sum
);

  localparam int OUT_LEN = BIT_LEN + 2;
  localparam int NUM_SEG = seg_count(OUT_LEN, SEG_LEN);
  localparam int LAST_W  = last_seg_len(OUT_LEN, SEG_LEN);

  logic               adv_s;
  logic [BIT_LEN-1:0] xor_s;
  logic [BIT_LEN-1:0] maj_s;
  logic               v0_r;
  logic [OUT_LEN-1:0] s0_r;
  logic [OUT_LEN-1:0] c0_r;

  logic               v_pipe_s     [0:NUM_SEG];
  logic               carry_pipe_s [0:NUM_SEG];
  logic [OUT_LEN-1:0] s_pipe_s     [0:NUM_SEG];
  logic [OUT_LEN-1:0] c_pipe_s     [0:NUM_SEG];
  logic [OUT_LEN-1:0] res_pipe_s   [0:NUM_SEG];
  logic               unused_s;

  // Whole pipe moves in lockstep; a held output freezes every stage.
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  // 3:2 reduction of the incoming triple.
  always_comb begin
    xor_s = C1 ^ C ^ S;
    maj_s = (C1 & C) | (C1 & S) | (C & S);
  end

  // CSA stage register; a cycle without in_valid loads a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_r <= 1'b0;
      s0_r <= '0;
      c0_r <= '0;
    end else if (adv_s) begin
      v0_r <= in_valid;
      s0_r <= {2'b00, xor_s};
      c0_r <= {1'b0, maj_s, 1'b0};
    end else begin
      v0_r <= v0_r;
      s0_r <= s0_r;
      c0_r <= c0_r;
    end
  end

  assign v_pipe_s[0]     = v0_r;
  assign carry_pipe_s[0] = 1'b0;
  assign s_pipe_s[0]     = s0_r;
  assign c_pipe_s[0]     = c0_r;
  assign res_pipe_s[0]   = '0;

  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    localparam int W = (k == NUM_SEG - 1) ? LAST_W : SEG_LEN;
    segment_carry_stage #(
      .OUT_LEN(OUT_LEN),
      .SEG_LEN(SEG_LEN),
      .SEG_IDX(k),
      .SEG_W  (W)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .adv      (adv_s),
      .v_in     (v_pipe_s[k]),
      .carry_in (carry_pipe_s[k]),
      .s_in     (s_pipe_s[k]),
      .c_in     (c_pipe_s[k]),
      .res_in   (res_pipe_s[k]),
      .v_out    (v_pipe_s[k+1]),
      .carry_out(carry_pipe_s[k+1]),
      .s_out    (s_pipe_s[k+1]),
      .c_out    (c_pipe_s[k+1]),
      .res_out  (res_pipe_s[k+1])
    );
  end

  // The top carry-out is always 0 and the forwarded operands are spent here.
  assign unused_s = ^{carry_pipe_s[NUM_SEG], s_pipe_s[NUM_SEG], c_pipe_s[NUM_SEG]};

  assign out_valid = v_pipe_s[NUM_SEG];
  assign sum       = res_pipe_s[NUM_SEG];

endmodule

// File: tb/tb_redundant_sum_resolver.sv
// Directed and random checks of redundant_sum_resolver in its default
// configuration (BIT_LEN=23, SEG_LEN=8: 4 segments, 5-cycle latency).
module tb_redundant_sum_resolver;

  localparam int BIT_LEN = 23;
  localparam int OUT_LEN = 25;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [BIT_LEN-1:0] c1;
  logic [BIT_LEN-1:0] c;
  logic [BIT_LEN-1:0] s;
  logic [OUT_LEN-1:0] sum;

  int checks = 0;
  int errors = 0;

  logic [OUT_LEN-1:0] exp_q [$];
  logic               stalled;
  logic [OUT_LEN-1:0] held_sum;

  always #5 clk = ~clk;

  redundant_sum_resolver #(.BIT_LEN(23), .SEG_LEN(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .C1       (c1),
    .C        (c),
    .S        (s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum)
  );

  function automatic logic [OUT_LEN-1:0] ref_sum(input logic [BIT_LEN-1:0] a,
                                                 input logic [BIT_LEN-1:0] b,
                                                 input logic [BIT_LEN-1:0] d);
    return OUT_LEN'(a) + OUT_LEN'(b) + OUT_LEN'(d);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    c1 = '0; c = '0; s = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 25'h0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_release_out_valid got=%b exp=0", out_valid); end
  endtask

  task automatic run_single(input string name, input logic [BIT_LEN-1:0] a,
                            input logic [BIT_LEN-1:0] b, input logic [BIT_LEN-1:0] d,
                            input logic [OUT_LEN-1:0] exp);
    int cycles;
    @(negedge clk);
    c1 = a; c = b; s = d; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept in_ready=%b exp=1", name, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 1;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    checks++; if (cycles != 5) begin errors++; $display("FAIL %s_latency got=%0d exp=5", name, cycles); end
    checks++; if (sum !== exp) begin errors++; $display("FAIL %s_sum got=%h exp=%h", name, sum, exp); end
  endtask

  task automatic test_back_to_back;
    int sent, got, first_cyc, last_cyc;
    logic [OUT_LEN-1:0] e;
    exp_q.delete();
    sent = 0; got = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 140 && got < 100; cyc++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got=%h exp=no output", sum);
        end else begin
          e = exp_q.pop_front();
          if (sum !== e) begin errors++; $display("FAIL b2b_sum idx=%0d got=%h exp=%h", got, sum, e); end
        end
        got++;
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
      out_ready = 1'b1;
      if (sent < 100) begin
        c1 = BIT_LEN'($urandom); c = BIT_LEN'($urandom); s = BIT_LEN'($urandom);
        in_valid = 1'b1;
        exp_q.push_back(ref_sum(c1, c, s));
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (got != 100) begin errors++; $display("FAIL b2b_count got=%0d exp=100", got); end
    checks++; if (last_cyc - first_cyc != 99) begin errors++; $display("FAIL b2b_rate got=%0d exp=99", last_cyc - first_cyc); end
  endtask

  task automatic rand_cycle(input bit allow_in, input bit force_ready);
    logic [OUT_LEN-1:0] e;
    logic exp_rdy;
    @(negedge clk);
    if (stalled) begin
      checks++;
      if (out_valid !== 1'b1 || sum !== held_sum) begin
        errors++; $display("FAIL stall_stable got=%b/%h exp=1/%h", out_valid, sum, held_sum);
      end
    end
    out_ready = force_ready ? 1'b1 : 1'($urandom_range(0, 1));
    stalled = 1'b0;
    if (out_valid === 1'b1) begin
      if (out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_dup got=%h exp=no output", sum);
        end else begin
          e = exp_q.pop_front();
          if (sum !== e) begin errors++; $display("FAIL rand_sum got=%h exp=%h", sum, e); end
        end
      end else begin
        stalled = 1'b1;
        held_sum = sum;
      end
    end
    in_valid = allow_in ? 1'($urandom_range(0, 1)) : 1'b0;
    c1 = BIT_LEN'($urandom); c = BIT_LEN'($urandom); s = BIT_LEN'($urandom);
    exp_rdy = (out_valid !== 1'b1) || out_ready;
    #1;
    checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_in_ready got=%b exp=%b", in_ready, exp_rdy); end
    if (in_valid && in_ready) exp_q.push_back(ref_sum(c1, c, s));
  endtask

  task automatic test_random_flow;
    exp_q.delete();
    stalled = 1'b0;
    for (int i = 0; i < 300; i++) rand_cycle(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) rand_cycle(1'b0, 1'b1);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_loss got=%0d pending exp=0", exp_q.size()); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_drain_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midflight;
    int waited;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      c1 = BIT_LEN'(i * 100); c = BIT_LEN'(i * 7); s = BIT_LEN'(i);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midflight_fill got=%b exp=1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midflight_rst_valid got=%b exp=0", out_valid); end
    checks++; if (sum !== 25'h0) begin errors++; $display("FAIL midflight_rst_sum got=%h exp=0", sum); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midflight_rst_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    run_single("after_reset", 23'd1, 23'd2, 23'd3, 25'd6);
  endtask

  initial begin
    test_reset();
    run_single("simple", 23'h000004, 23'h000002, 23'h000001, 25'h0000007);
    run_single("max", 23'h7FFFFF, 23'h7FFFFF, 23'h7FFFFF, 25'h17FFFFD);
    run_single("carry_seg", 23'h0000FF, 23'h000001, 23'h000000, 25'h0000100);
    run_single("carry_long", 23'h7FFFFF, 23'h000001, 23'h000000, 25'h0800000);
    test_back_to_back();
    test_random_flow();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
